// File: rtl/dmem_arbiter.sv
// Data-memory arbiter sharing one single-port memory between the core and
// the BNN accelerator. The core normally has priority; a BNN request that
// has been denied for MAX_WAIT cycles takes precedence at the next
// arbitration. One access is in flight at a time. The memory signals
// completion with m_ready, and its latency is variable.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  output logic              stall,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [31:0]       m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_C = 2'd1,
    BUSY_B = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic       b_starved;
  logic       win_c;
  logic       win_b;
  logic       finish;

  // The BNN overrides the core only once it has waited the full budget.
  assign b_starved = b_req && (wait_cnt == WAIT_LIM);

  // The memory is busy for as long as an access is owned by either side.
  assign m_en  = (state != IDLE);
  assign stall = c_req & ~c_done;

  // Arbitration in IDLE, completion tracking in BUSY; m_ready is only honoured while busy.
  always_comb begin
    state_nxt = state;
    win_c     = 1'b0;
    win_b     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (c_req && !b_starved) begin
          state_nxt = BUSY_C;
          win_c     = 1'b1;
        end else if (b_req) begin
          state_nxt = BUSY_B;
          win_b     = 1'b1;
        end
      end
      BUSY_C, BUSY_B: begin
        if (m_ready) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and BNN starvation counter (saturating, cleared when BNN is granted).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (win_b) begin
        wait_cnt <= 4'd0;
      end else if (b_req && (state_nxt != BUSY_B) && (wait_cnt < WAIT_LIM)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  // Grant/done pulses, payload latching at grant, and per-requester load data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_gnt   <= 1'b0;
      b_gnt   <= 1'b0;
      c_done  <= 1'b0;
      b_done  <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= 32'd0;
      m_wdata <= '0;
      c_rdata <= '0;
      b_rdata <= '0;
    end else begin
      c_gnt  <= win_c;
      b_gnt  <= win_b;
      c_done <= finish && (state == BUSY_C);
      b_done <= finish && (state == BUSY_B);
      if (win_c) begin
        m_we    <= c_we;
        m_addr  <= c_addr;
        m_wdata <= c_wdata;
      end else if (win_b) begin
        m_we    <= b_we;
        m_addr  <= b_addr;
        m_wdata <= b_wdata;
      end else if (finish) begin
        m_we    <= 1'b0;
      end
      if (finish && !m_we) begin
        if (state == BUSY_C) begin
          c_rdata <= m_rdata;
        end else begin
          b_rdata <= m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized
// traffic. Every cycle is compared against a transaction-level model of the
// arbiter.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, b_req, b_we, m_ready;
  logic [31:0] c_addr, c_wdata, b_addr, b_wdata, m_rdata;
  logic        c_gnt, c_done, b_gnt, b_done, stall, m_en, m_we;
  logic [31:0] c_rdata, b_rdata, m_addr, m_wdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata), .stall(stall),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: who owns the memory (0 none, 1 core, 2 BNN), how long the
  // BNN has been kept waiting, and the values each output should show.
  int          owner;
  int          waited;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata, e_c_rdata, e_b_rdata;
  logic        e_c_gnt, e_b_gnt, e_c_done, e_b_done;

  task automatic model_clear();
    owner = 0; waited = 0; lat_we = 0; lat_addr = 0; lat_wdata = 0;
    e_c_rdata = 0; e_b_rdata = 0;
    e_c_gnt = 0; e_b_gnt = 0; e_c_done = 0; e_b_done = 0;
  endtask

  task automatic model_edge();
    int nxt;
    if (!reset) begin
      model_clear();
    end else begin
      e_c_gnt = 0; e_b_gnt = 0; e_c_done = 0; e_b_done = 0;
      nxt = owner;
      if (owner == 0) begin
        if (c_req && !(b_req && waited == MAX_WAIT)) begin
          nxt = 1; e_c_gnt = 1;
          lat_we = c_we; lat_addr = c_addr; lat_wdata = c_wdata;
        end else if (b_req) begin
          nxt = 2; e_b_gnt = 1;
          lat_we = b_we; lat_addr = b_addr; lat_wdata = b_wdata;
        end
      end else if (m_ready) begin
        if (owner == 1) begin
          e_c_done = 1;
          if (!lat_we) e_c_rdata = m_rdata;
        end else begin
          e_b_done = 1;
          if (!lat_we) e_b_rdata = m_rdata;
        end
        nxt = 0;
      end
      if (nxt == 2 && owner != 2) waited = 0;
      else if (b_req && nxt != 2) waited = (waited + 1 > MAX_WAIT) ? MAX_WAIT : waited + 1;
      owner = nxt;
    end
  endtask

  task automatic check_all();
    check("m_en",    {31'd0, m_en},   {31'd0, owner != 0});
    check("m_we",    {31'd0, m_we},   {31'd0, (owner != 0) && lat_we});
    check("m_addr",  m_addr,          lat_addr);
    check("m_wdata", m_wdata,         lat_wdata);
    check("c_gnt",   {31'd0, c_gnt},  {31'd0, e_c_gnt});
    check("b_gnt",   {31'd0, b_gnt},  {31'd0, e_b_gnt});
    check("c_done",  {31'd0, c_done}, {31'd0, e_c_done});
    check("b_done",  {31'd0, b_done}, {31'd0, e_b_done});
    check("c_rdata", c_rdata,         e_c_rdata);
    check("b_rdata", b_rdata,         e_b_rdata);
  endtask

  // One clock: check the combinational stall, advance the model, then compare after the edge.
  task automatic tick();
    #1;
    check("stall", {31'd0, stall}, {31'd0, c_req & ~e_c_done});
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  bit c_pend, b_pend;
  int seq_c_first, b_wins, after_b_core, seen_b, gnt_after_b;

  initial begin
    reset = 0; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; m_ready = 0; m_rdata = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_m_en", {31'd0, m_en}, 32'd0);

    // Core load, memory answers two cycles after m_en rises
    reset = 1;
    c_req = 1; c_we = 0; c_addr = 32'h100;
    tick();
    check("ld_gnt", {31'd0, c_gnt}, 32'd1);
    check("ld_addr", m_addr, 32'h100);
    tick();
    check("ld_stall_busy", {31'd0, stall}, 32'd1);
    m_ready = 1; m_rdata = 32'hDEADBEEF;
    tick();
    check("ld_done", {31'd0, c_done}, 32'd1);
    check("ld_rdata", c_rdata, 32'hDEADBEEF);
    check("ld_stall_fall", {31'd0, stall}, 32'd0);
    c_req = 0; m_ready = 0;
    tick();

    // BNN store; payload scrambled right after the grant
    b_req = 1; b_we = 1; b_addr = 32'h200; b_wdata = 32'h12345678;
    tick();
    check("st_gnt", {31'd0, b_gnt}, 32'd1);
    check("st_we", {31'd0, m_we}, 32'd1);
    check("st_wdata", m_wdata, 32'h12345678);
    b_req = 0; b_wdata = 32'hA5A5A5A5; b_addr = 32'h0; m_ready = 1; m_rdata = 32'hCAFEF00D;
    tick();
    check("st_done", {31'd0, b_done}, 32'd1);
    check("st_rdata_kept", b_rdata, 32'd0);
    check("st_addr_kept", m_addr, 32'h200);
    check("st_we_idle", {31'd0, m_we}, 32'd0);

    // Stray strobe in IDLE
    tick();
    check("stray_cdone", {31'd0, c_done}, 32'd0);
    check("stray_bdone", {31'd0, b_done}, 32'd0);
    m_ready = 0;

    // BNN request arriving during a core access
    c_req = 1; c_we = 0; c_addr = 32'h300;
    tick();
    c_req = 0; b_req = 1; b_we = 0; b_addr = 32'h400;
    tick();
    check("late_b_wait", {31'd0, b_gnt}, 32'd0);
    m_ready = 1; m_rdata = 32'h0BADF00D;
    tick();
    check("late_c_done", {31'd0, c_done}, 32'd1);
    check("late_b_nogo", {31'd0, b_gnt}, 32'd0);
    m_ready = 0;
    tick();
    check("late_b_gnt", {31'd0, b_gnt}, 32'd1);
    b_req = 0; m_ready = 1; m_rdata = 32'h77778888;
    tick();
    check("late_b_rdata", b_rdata, 32'h77778888);
    m_ready = 0;

    // Reset during a core access; a strobe after release must be ignored
    c_req = 1; c_addr = 32'h500;
    tick();
    c_req = 0; reset = 0;
    tick();
    check("mid_rst_men", {31'd0, m_en}, 32'd0);
    check("mid_rst_rdata", c_rdata, 32'd0);
    reset = 1; m_ready = 1; m_rdata = 32'h55555555;
    tick();
    check("mid_rst_nodone", {31'd0, c_done}, 32'd0);
    m_ready = 0;
    tick();

    // Request present in the first cycle after reset release
    reset = 0; c_req = 1; c_addr = 32'h600;
    tick();
    reset = 1;
    tick();
    check("post_rst_gnt", {31'd0, c_gnt}, 32'd1);
    c_req = 0; m_ready = 1; m_rdata = 32'h11112222;
    tick();
    m_ready = 0;

    // Starvation guard: both requesters held high, single-cycle memory
    reset = 0;
    tick();
    reset = 1; c_req = 1; b_req = 1; c_we = 0; b_we = 0; m_ready = 1;
    seq_c_first = -1; b_wins = 0; after_b_core = 0; seen_b = 0; gnt_after_b = 0;
    for (int i = 0; i < 24; i++) begin
      m_rdata = $urandom;
      tick();
      if (seq_c_first < 0 && (c_gnt || b_gnt)) seq_c_first = c_gnt ? 1 : 0;
      if (seen_b && !gnt_after_b && (c_gnt || b_gnt)) begin
        gnt_after_b = 1; after_b_core = c_gnt ? 1 : 0;
      end
      if (b_gnt) begin b_wins++; seen_b = 1; end
    end
    check("starve_core_first", seq_c_first, 32'd1);
    check("starve_b_wins", {31'd0, b_wins > 0}, 32'd1);
    check("starve_core_after_b", after_b_core, 32'd1);
    c_req = 0; b_req = 0; m_ready = 0;
    tick();

    // Randomized traffic
    c_pend = 0; b_pend = 0;
    for (int i = 0; i < 3000; i++) begin
      if (c_gnt) c_pend = 0;
      if (b_gnt) b_pend = 0;
      if (!c_pend) begin
        c_we = 1'($urandom_range(0, 1)); c_addr = $urandom; c_wdata = $urandom;
        c_req = ($urandom_range(0, 99) < 35); c_pend = c_req;
      end
      if (!b_pend) begin
        b_we = 1'($urandom_range(0, 1)); b_addr = $urandom; b_wdata = $urandom;
        b_req = ($urandom_range(0, 99) < 30); b_pend = b_req;
      end
      m_ready = ($urandom_range(0, 99) < 40);
      m_rdata = $urandom;
      reset = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
